// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: next-PC selection, redirect arbitration and imem handshake.
// Optional macro MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VECTOR.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
    parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0000_0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        RedirectE,
    input  logic [63:0] PCTargetE,
    input  logic        JalrM,
    input  logic [63:0] ALUResultM,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [63:0] PCF,
    output logic [63:0] PCPlus4F,
    output logic [1:0]  PCSrcE,
    output logic        InstrValidF,
    output logic        FlushD,
    output logic        FlushE,
    output logic        MisalignF
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pcf_q, pcf_d;
    logic [63:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misalign_q, misalign_d;

    logic        redir;
    logic        target_bad;
    logic [63:0] target_raw;
    logic [63:0] target;

    assign redir    = JalrM | RedirectE;
    assign PCPlus4F = pcf_q + 64'd4;

    // JalrM belongs to the older instruction, so it wins the target choice.
    always_comb begin
        target_raw = JalrM ? ALUResultM : PCTargetE;
`ifdef MISALIGN_TRAP_EN
        target_bad = (target_raw[1:0] != 2'b00);
        target     = target_bad ? TRAP_VECTOR : target_raw;
`else
        target_bad = 1'b0;
        target     = target_raw & ~64'h3;
`endif
    end

`ifndef MISALIGN_TRAP_EN
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pcf_q         <= RESET_VECTOR;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    // FETCH and WAIT share one rule set; pend_valid_q is only ever set in WAIT.
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        instr_valid_d = 1'b0;
        misalign_d    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                if (redir) begin
                    misalign_d = target_bad;
                    if (imem_ready) begin
                        pcf_d        = target;
                        pend_valid_d = 1'b0;
                        state_d      = ST_FETCH;
                    end else begin
                        pend_target_d = target;
                        pend_valid_d  = 1'b1;
                        state_d       = ST_WAIT;
                    end
                end else if (!imem_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                    if (pend_valid_q) begin
                        pcf_d        = pend_target_q;
                        pend_valid_d = 1'b0;
                    end else if (!StallF) begin
                        pcf_d         = PCPlus4F;
                        instr_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        imem_req = (state_q != ST_BOOT);
        FlushD   = redir;
        FlushE   = redir;
        if (JalrM) begin
            PCSrcE = 2'b10;
        end else if (RedirectE) begin
            PCSrcE = 2'b01;
        end else begin
            PCSrcE = 2'b00;
        end
    end

    assign PCF         = pcf_q;
    assign InstrValidF = instr_valid_q;
`ifdef MISALIGN_TRAP_EN
    assign MisalignF   = misalign_q;
`else
    assign MisalignF   = 1'b0;
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule
